// File: rtl/mul_seq_unit.sv
// Sequential shift-add multiplier with optional signed mode and early termination.
// Signed operands are reduced to magnitudes; the sign is reapplied on the final write.
module mul_seq_unit #(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_EN  = 1'b1,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [PW-1:0]     ma_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     prod_q;
    logic [WIDTH-1:0]  mb_q;
    logic [CW-1:0]     cnt_q;
    logic              sign_q;
    logic              busy_q;
    logic              done_q;

    logic              smode;
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic              term;
    logic [PW-1:0]     acc_d;
    logic [PW-1:0]     res_d;

    always_comb begin
        smode = SIGNED_EN && signed_mode;
        a_neg = smode && a[WIDTH-1];
        b_neg = smode && b[WIDTH-1];
        // Most negative value maps to 2^(WIDTH-1), which still fits unsigned
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
        term  = EARLY_TERM ? (mb_q == '0) : (cnt_q == CW'(WIDTH));
        acc_d = mb_q[0] ? (acc_q + ma_q) : acc_q;
        res_d = sign_q ? (~acc_q + 1'b1) : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ma_q    <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        ma_q    <= {{WIDTH{1'b0}}, a_mag};
                        mb_q    <= b_mag;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        sign_q  <= a_neg ^ b_neg;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (term) begin
                        prod_q  <= res_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        ma_q  <= ma_q << 1;
                        mb_q  <= mb_q >> 1;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Scoreboard bench for mul_seq_unit: default instance plus a
// full-length, unsigned-only instance.
module tb_mul_seq_unit;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start0 = 1'b0, sm0 = 1'b0;
    logic          start1 = 1'b0, sm1 = 1'b0;
    logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic          busy0, done0, busy1, done1;
    logic [2*W-1:0] p0, p1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [2*W-1:0] p;
        longint         t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    mul_seq_unit #(.WIDTH(W), .SIGNED_EN(1'b1), .EARLY_TERM(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(sm0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .product(p0)
    );

    mul_seq_unit #(.WIDTH(W), .SIGNED_EN(1'b0), .EARLY_TERM(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(sm1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .product(p1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x,
                                                input logic [W-1:0] y,
                                                input bit sm);
        longint xv, yv;
        xv = sm ? longint'($signed(x)) : longint'(x);
        yv = sm ? longint'($signed(y)) : longint'(y);
        return (2*W)'(xv * yv);
    endfunction

    function automatic int ref_lat(input logic [W-1:0] y, input bit sm,
                                   input bit et);
        int v, k;
        if (!et) return W + 1;
        v = sm ? int'($signed(y)) : int'(y);
        if (v < 0) v = -v;
        k = 0;
        while (v != 0) begin
            v = v >> 1;
            k++;
        end
        return k + 1;
    endfunction

    task automatic issue(input int u, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit sm);
        int n;
        longint ts;
        exp_t e;
        bit smeff;
        n = 0;
        @(negedge clk);
        while ((u == 0 ? busy0 : busy1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (u == 0 ? busy0 : busy1) begin
            chk("issue_wait", 1, 0);
            return;
        end
        smeff = (u == 0) ? sm : 1'b0;
        if (u == 0) begin
            a0 = x; b0 = y; sm0 = sm; start0 = 1'b1;
        end else begin
            a1 = x; b1 = y; sm1 = sm; start1 = 1'b1;
        end
        @(posedge clk);
        ts = longint'($time);
        e.p = ref_prod(x, y, smeff);
        e.t = ts + 10 * ref_lat(y, smeff, u == 0) + 5;
        if (u == 0) q0.push_back(e);
        else q1.push_back(e);
        @(negedge clk);
        // Scramble inputs while busy; the result must not change
        if (u == 0) begin
            start0 = 1'b0; a0 = W'($urandom); b0 = W'($urandom);
            sm0 = 1'($urandom);
        end else begin
            start1 = 1'b0; a1 = W'($urandom); b1 = W'($urandom);
            sm1 = 1'($urandom);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done0) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done0_unexpected got=1 want=0 at %0t", $time);
            end else begin
                e = q0.pop_front();
                chk("prod0", p0, e.p);
                chk("lat0", longint'($time), e.t);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done1_unexpected got=1 want=0 at %0t", $time);
            end else begin
                e = q1.pop_front();
                chk("prod1", p1, e.p);
                chk("lat1", longint'($time), e.t);
            end
        end
    end

    initial begin
        int n;
        logic [W-1:0] x, y;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_prod0", p0, 0);
        chk("rst_prod1", p1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(0, 8'd13, 8'd11, 1'b0);
        issue(0, 8'h80, 8'h80, 1'b1);
        issue(0, 8'd7, 8'hFD, 1'b1);
        issue(0, 8'h00, 8'h9C, 1'b1);

        issue(0, 8'hFF, 8'h00, 1'b0);
        chk("busy_run", busy0, 1);
        @(negedge clk);
        chk("busy_done", busy0, 1);
        @(negedge clk);
        chk("busy_idle", busy0, 0);

        issue(0, 8'd13, 8'd11, 1'b0);
        a0 = 8'd2; b0 = 8'd2; sm0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done0, 1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("ignored_start", busy0, 0);
        issue(0, 8'd2, 8'd2, 1'b0);

        issue(0, 8'hFF, 8'hFF, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        q0.delete();
        #1;
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_prod", p0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 8'd3, 8'd5, 1'b0);

        for (int i = 0; i < 60; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            case ($urandom_range(0, 5))
                0: y = 8'h00;
                1: x = 8'h80;
                2: y = 8'h80;
                3: y = W'($urandom_range(0, 3));
                default: ;
            endcase
            issue(0, x, y, 1'($urandom));
        end

        issue(1, 8'd13, 8'd1, 1'b0);
        issue(1, 8'hFF, 8'h02, 1'b1);
        issue(1, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++)
            issue(1, W'($urandom), W'($urandom), 1'($urandom));

        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
